square_motion_ctrl: RTL and testbench

Frame-synchronous controller that owns the position of the on-screen square and tells the pixel path when the current pixel lies inside it. It synchronises and debounces the four direction buttons, and updates the square's X/Y once per frame at the start of vertical sync, so position never changes mid-frame. It also tracks active-area pixel coordinates. It sits between the board buttons and the colour-index mux ahead of the palette lookup, and runs on the VGA pixel clock.

---
 rtl/square_motion_ctrl.sv | 121 ++++++++++++
 tb/tb_square_motion_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl.sv
// square_motion_ctrl: debounced button-driven square position, updated once per frame,
// plus active-area pixel counters and a registered in-square flag for the pixel path.
module square_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SQ_SIZE         = 32,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int X_INIT          = 304,
    parameter int Y_INIT          = 224
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic       iBLANK_n,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oIN_SQUARE,
    output logic       oFRAME_TICK,
    output logic       oMOVING
);
    localparam logic [10:0] X_LIM11  = 11'(H_ACTIVE - SQ_SIZE);
    localparam logic [9:0]  X_LIM10  = 10'(H_ACTIVE - SQ_SIZE);
    localparam logic [9:0]  Y_LIM10  = 10'(V_ACTIVE - SQ_SIZE);
    localparam logic [8:0]  Y_LIM9   = 9'(V_ACTIVE - SQ_SIZE);
    localparam logic [10:0] X_STEP11 = 11'(STEP);
    localparam logic [9:0]  X_STEP10 = 10'(STEP);
    localparam logic [9:0]  Y_STEP10 = 10'(STEP);
    localparam logic [8:0]  Y_STEP9  = 9'(STEP);
    localparam logic [10:0] X_SIZE   = 11'(SQ_SIZE);
    localparam logic [9:0]  Y_SIZE   = 10'(SQ_SIZE);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE_FRAMES);
    localparam logic [9:0]  PX_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  PY_MAX   = 9'(V_ACTIVE - 1);

    // button order: {down, up, right, left}
    logic [3:0]  sync1, sync2, act;
    logic [3:0]  cnt [4];
    logic        vs_d, blank_d, tick, blank_fall, in_sq;
    logic [9:0]  px, x_new;
    logic [8:0]  py, y_new;
    logic [10:0] x_sum;
    logic [9:0]  y_sum;

    assign tick        = vs_d & ~iVS;
    assign oFRAME_TICK = tick;
    assign blank_fall  = blank_d & ~iBLANK_n;

    for (genvar g = 0; g < 4; g++) begin : g_act
        assign act[g] = cnt[g] == DB;
    end

    // sums carry one extra bit so the clamp sees the true value
    assign x_sum = {1'b0, oX} + X_STEP11;
    assign y_sum = {1'b0, oY} + Y_STEP10;

    always_comb begin
        x_new = (act[1] & ~act[0]) ? ((x_sum > X_LIM11) ? X_LIM10 : x_sum[9:0]) :
                (act[0] & ~act[1]) ? ((oX < X_STEP10) ? 10'd0 : oX - X_STEP10) : oX;
        y_new = (act[3] & ~act[2]) ? ((y_sum > Y_LIM10) ? Y_LIM9 : y_sum[8:0]) :
                (act[2] & ~act[3]) ? ((oY < Y_STEP9) ? 9'd0 : oY - Y_STEP9) : oY;
        in_sq = iBLANK_n & (px >= oX) & ({1'b0, px} < {1'b0, oX} + X_SIZE) &
                (py >= oY) & ({1'b0, py} < {1'b0, oY} + Y_SIZE);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1   <= '0;
            sync2   <= '0;
            vs_d    <= 1'b1;
            blank_d <= 1'b0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1   <= {down, up, right, left};
            sync2   <= sync1;
            vs_d    <= iVS;
            blank_d <= iBLANK_n;
            if (tick)
                for (int i = 0; i < 4; i++)
                    cnt[i] <= sync2[i] ? (act[i] ? cnt[i] : cnt[i] + 4'd1) : 4'd0;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oX      <= 10'(X_INIT);
            oY      <= 9'(Y_INIT);
            oMOVING <= 1'b0;
        end else begin
            oMOVING <= tick & ((x_new != oX) | (y_new != oY));
            if (tick) begin
                oX <= x_new;
                oY <= y_new;
            end
        end
    end

    // frame tick wins over a coincident blank edge
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            px         <= '0;
            py         <= '0;
            oIN_SQUARE <= 1'b0;
        end else begin
            oIN_SQUARE <= in_sq;
            if (tick) begin
                px <= '0;
                py <= '0;
            end else if (blank_fall) begin
                px <= '0;
                py <= (py == PY_MAX) ? py : py + 9'd1;
            end else if (iBLANK_n && px != PX_MAX) begin
                px <= px + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb_square_motion_ctrl: scoreboard bench for square_motion_ctrl; a main instance at the
// default position plus two instances parked near the edges for clamp checks.
module tb_square_motion_ctrl;
    logic       clk = 1'b0, rst_n = 1'b1, vs = 1'b1, blank = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [9:0] x, x_hi, x_lo;
    logic [8:0] y, y_hi, y_lo;
    logic       insq, tk, mv, insq_hi, tk_hi, mv_hi, insq_lo, tk_lo, mv_lo;

    always #5 clk = ~clk;

    square_motion_ctrl u_dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBLANK_n(blank),
        .left(btn[0]), .right(btn[1]), .up(btn[2]), .down(btn[3]),
        .oX(x), .oY(y), .oIN_SQUARE(insq), .oFRAME_TICK(tk), .oMOVING(mv));

    square_motion_ctrl #(.X_INIT(606), .Y_INIT(446)) u_hi (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBLANK_n(blank),
        .left(btn[0]), .right(btn[1]), .up(btn[2]), .down(btn[3]),
        .oX(x_hi), .oY(y_hi), .oIN_SQUARE(insq_hi), .oFRAME_TICK(tk_hi), .oMOVING(mv_hi));

    square_motion_ctrl #(.X_INIT(2), .Y_INIT(2)) u_lo (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBLANK_n(blank),
        .left(btn[0]), .right(btn[1]), .up(btn[2]), .down(btn[3]),
        .oX(x_lo), .oY(y_lo), .oIN_SQUARE(insq_lo), .oFRAME_TICK(tk_lo), .oMOVING(mv_lo));

    typedef struct {int x; int y; int mv;} pos_t;
    pos_t pq[$];
    int   sq[$];
    int   checks = 0, errors = 0;
    int   mx, my, moves, hi_cnt, lp, ll, first_p, first_l;
    int   mcnt[4];
    bit   seen;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 304;
        my = 224;
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
    endtask

    task automatic do_reset();
        btn = 4'b0000;
        #3 rst_n = 1'b0;
        #1;
        check("rst_x", x, 304);
        check("rst_y", y, 224);
        check("rst_insq", insq, 0);
        check("rst_moving", mv, 0);
        check("rst_tick", tk, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] v);
        @(negedge clk) btn = v;
        repeat (2) @(negedge clk);
    endtask

    // one vsync falling edge; the move is predicted from the flags held before it
    task automatic frame_tick();
        pos_t e;
        int   nx, ny;
        bit   a[4];
        for (int i = 0; i < 4; i++) a[i] = mcnt[i] == 3;
        nx = mx;
        ny = my;
        if (a[1] && !a[0]) nx = (mx + 4 > 608) ? 608 : mx + 4;
        else if (a[0] && !a[1]) nx = (mx < 4) ? 0 : mx - 4;
        if (a[3] && !a[2]) ny = (my + 4 > 448) ? 448 : my + 4;
        else if (a[2] && !a[3]) ny = (my < 4) ? 0 : my - 4;
        for (int i = 0; i < 4; i++) mcnt[i] = btn[i] ? ((mcnt[i] == 3) ? 3 : mcnt[i] + 1) : 0;
        e.x  = nx;
        e.y  = ny;
        e.mv = int'(nx != mx || ny != my);
        mx   = nx;
        my   = ny;
        @(negedge clk);
        vs = 1'b0;
        pq.push_back(e);
        #1 check("frame_tick", tk, 1);
        @(negedge clk);
        e = pq.pop_front();
        check("x", x, e.x);
        check("y", y, e.y);
        check("moving", mv, e.mv);
        check("tick_pulse", tk, 0);
        if (mv) moves++;
        vs = 1'b1;
        repeat (3) @(negedge clk);
        check("moving_drop", mv, 0);
    endtask

    task automatic pix(input bit b, input int p, input int l);
        @(negedge clk);
        if (sq.size() > 0) begin
            check("insq", insq, sq.pop_front());
            if (insq) begin
                hi_cnt++;
                if (!seen) begin
                    seen    = 1'b1;
                    first_p = lp;
                    first_l = ll;
                end
            end
        end
        blank = b;
        sq.push_back(int'(b && l >= 224 && l < 256 && p >= 304 && p < 336));
        lp = p;
        ll = l;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("init_x", x, 304);
        check("init_y", y, 224);
        check("init_insq", insq, 0);
        check("init_moving", mv, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        moves = 0;
        set_btn(4'b0010);
        repeat (3) frame_tick();
        check("right_debounce_x", x, 304);
        frame_tick();
        check("right_t4_x", x, 308);
        frame_tick();
        check("right_t5_x", x, 312);
        check("right_y", y, 224);
        check("right_moves", moves, 2);
        do_reset();

        set_btn(4'b0011);
        repeat (6) frame_tick();
        check("opposing_x", x, 304);
        do_reset();

        set_btn(4'b0110);
        repeat (5) frame_tick();
        check("diag_x", x, 312);
        check("diag_y", y, 216);
        do_reset();

        set_btn(4'b1000);
        repeat (2) frame_tick();
        set_btn(4'b0000);
        frame_tick();
        set_btn(4'b1000);
        repeat (2) frame_tick();
        check("glitch_y", y, 224);
        do_reset();

        set_btn(4'b1010);
        repeat (3) frame_tick();
        check("clamp_hi_pre_x", x_hi, 606);
        frame_tick();
        check("clamp_hi_x", x_hi, 608);
        check("clamp_hi_y", y_hi, 448);
        repeat (2) frame_tick();
        check("clamp_hi_hold_x", x_hi, 608);
        check("clamp_hi_hold_y", y_hi, 448);
        do_reset();

        set_btn(4'b0101);
        repeat (4) frame_tick();
        check("clamp_lo_x", x_lo, 0);
        check("clamp_lo_y", y_lo, 0);
        frame_tick();
        check("clamp_lo_hold_x", x_lo, 0);
        do_reset();

        hi_cnt = 0;
        seen   = 1'b0;
        lp     = -1;
        ll     = -1;
        for (int l = 0; l < 258; l++) begin
            for (int p = 0; p < ((l < 222) ? 1 : 340); p++) pix(1'b1, p, l);
            repeat (2) pix(1'b0, 0, l);
        end
        pix(1'b0, 0, 0);
        check("insq_count", hi_cnt, 1024);
        check("insq_seen", seen, 1);
        check("insq_first_px", first_p, 304);
        check("insq_first_py", first_l, 224);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
